// File: rtl/rr_arb2.sv
`default_nettype none
// ============================================================================
//  Module      : rr_arb2
//  Description : Two-source round-robin arbiter for a shared valid/ready sink.
//                A grant lasts up to BURST transfers, then passes to the other
//                source if it is waiting. Drives the 2:1 data mux select and
//                gates each source's ready.
//  Revision    : 1.0 - initial release
// ============================================================================
module rr_arb2 #(
    parameter int WIDTH = 8,
    parameter int BURST = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in0_valid,
    input  logic [WIDTH-1:0] in0_data,
    output logic             in0_ready,
    input  logic             in1_valid,
    input  logic [WIDTH-1:0] in1_data,
    output logic             in1_ready,
    output logic             out_valid,
    output logic [WIDTH-1:0] out_data,
    input  logic             out_ready,
    output logic             sel,
    output logic [1:0]       grant
);

    localparam int               c_CNT_W    = $clog2(BURST + 1);
    localparam logic [c_CNT_W-1:0] c_CNT_LAST = c_CNT_W'(BURST - 1);
    localparam logic [c_CNT_W-1:0] c_CNT_ONE  = c_CNT_W'(1);

    localparam logic [1:0] c_ST_IDLE = 2'd0;
    localparam logic [1:0] c_ST_G0   = 2'd1;
    localparam logic [1:0] c_ST_G1   = 2'd2;

    logic [1:0]         r_state;
    logic [c_CNT_W-1:0] r_cnt;
    logic               r_last;

    logic [1:0]         w_state_nxt;
    logic [c_CNT_W-1:0] w_cnt_nxt;
    logic               w_last_nxt;

    logic               w_owner;
    logic               w_own_valid;
    logic               w_oth_valid;
    logic [1:0]         w_oth_state;
    logic               w_xfer;

    // Owner-relative views so the G0/G1 rules can be written once.
    assign w_owner     = (r_state == c_ST_G1);
    assign w_own_valid = w_owner ? in1_valid : in0_valid;
    assign w_oth_valid = w_owner ? in0_valid : in1_valid;
    assign w_oth_state = w_owner ? c_ST_G0 : c_ST_G1;

    // Outputs decode straight from state; valid/ready are masked during reset
    // so no beat completes in the reset cycle.
    assign grant     = {r_state == c_ST_G1, r_state == c_ST_G0};
    assign sel       = w_owner;
    assign out_data  = sel ? in1_data : in0_data;
    assign out_valid = !reset && ((grant[0] && in0_valid) || (grant[1] && in1_valid));
    assign in0_ready = !reset && grant[0] && out_ready;
    assign in1_ready = !reset && grant[1] && out_ready;
    assign w_xfer    = out_valid && out_ready;

    // Next-state, burst count and last-served selection.
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_last_nxt  = r_last;
        case (r_state)
            c_ST_IDLE: begin
                w_cnt_nxt = '0;
                if (in0_valid && in1_valid) begin
                    // last==1 means source 1 was served most recently, so 0 wins.
                    w_state_nxt = r_last ? c_ST_G0 : c_ST_G1;
                end else if (in0_valid) begin
                    w_state_nxt = c_ST_G0;
                end else if (in1_valid) begin
                    w_state_nxt = c_ST_G1;
                end
            end
            c_ST_G0, c_ST_G1: begin
                if (w_xfer) begin
                    if (r_cnt == c_CNT_LAST) begin
                        // Burst complete: rotate only if the other side waits.
                        w_last_nxt = w_owner;
                        w_cnt_nxt  = '0;
                        if (w_oth_valid) begin
                            w_state_nxt = w_oth_state;
                        end
                    end else begin
                        w_cnt_nxt = r_cnt + c_CNT_ONE;
                    end
                end else if (!w_own_valid) begin
                    // Owner dropped valid: treat as release.
                    w_last_nxt  = w_owner;
                    w_cnt_nxt   = '0;
                    w_state_nxt = w_oth_valid ? w_oth_state : c_ST_IDLE;
                end
                // Stalled sink with owner valid: hold everything.
            end
            default: begin
                w_state_nxt = c_ST_IDLE;
                w_cnt_nxt   = '0;
            end
        endcase
    end

    // State register with synchronous active-high reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= c_ST_IDLE;
            r_cnt   <= '0;
            r_last  <= 1'b1;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_last  <= w_last_nxt;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_rr_arb2.sv
`default_nettype none
// ============================================================================
//  Module      : tb_rr_arb2
//  Description : Self-checking bench for rr_arb2: directed scenarios with
//                literal expectations followed by randomized traffic compared
//                against a grant/beat-count reference model every cycle.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_rr_arb2;

    localparam int WIDTH = 8;
    localparam int BURST = 4;

    logic             clk;
    logic             reset;
    logic             in0_valid;
    logic [WIDTH-1:0] in0_data;
    logic             in0_ready;
    logic             in1_valid;
    logic [WIDTH-1:0] in1_data;
    logic             in1_ready;
    logic             out_valid;
    logic [WIDTH-1:0] out_data;
    logic             out_ready;
    logic             sel;
    logic [1:0]       grant;

    int checks = 0;
    int errors = 0;

    rr_arb2 #(.WIDTH(WIDTH), .BURST(BURST)) dut (
        .clk       (clk),
        .reset     (reset),
        .in0_valid (in0_valid),
        .in0_data  (in0_data),
        .in0_ready (in0_ready),
        .in1_valid (in1_valid),
        .in1_data  (in1_data),
        .in1_ready (in1_ready),
        .out_valid (out_valid),
        .out_data  (out_data),
        .out_ready (out_ready),
        .sel       (sel),
        .grant     (grant)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s actual=%0d required=%0d at %0t", nm, act, exp, $time);
        end
    endtask

    // Reference model: who owns the sink (-1 none), beats moved in this
    // grant, and who was served last.
    typedef struct {
        int owner;
        int beats;
        int last;
    } mstate_t;

    mstate_t m;
    bit      m_known = 1'b0;

    function automatic mstate_t model_step(mstate_t s, logic v0, logic v1, logic rdy);
        mstate_t n = s;
        logic    vn;
        logic    vo;
        int      oth;
        if (s.owner < 0) begin
            n.beats = 0;
            if (v0 && v1)  n.owner = (s.last == 1) ? 0 : 1;
            else if (v0)   n.owner = 0;
            else if (v1)   n.owner = 1;
        end else begin
            vn  = (s.owner == 1) ? v1 : v0;
            vo  = (s.owner == 1) ? v0 : v1;
            oth = 1 - s.owner;
            if (vn && rdy) begin
                n.beats = s.beats + 1;
                if (n.beats == BURST) begin
                    n.beats = 0;
                    n.last  = s.owner;
                    if (vo) n.owner = oth;
                end
            end else if (!vn) begin
                n.beats = 0;
                n.last  = s.owner;
                n.owner = vo ? oth : -1;
            end
        end
        return n;
    endfunction

    // Model advances on the same edge as the DUT.
    always @(posedge clk) begin
        if (reset) begin
            m       <= '{owner: -1, beats: 0, last: 1};
            m_known <= 1'b1;
        end else if (m_known) begin
            m <= model_step(m, in0_valid, in1_valid, out_ready);
        end
    end

    logic seen0;
    logic seen1;

    // Compare every cycle mid-period, once the model has seen a reset.
    always @(negedge clk) begin
        seen0 <= in0_ready;
        seen1 <= in1_ready;
        if (m_known) begin
            chk("grant", int'(grant), (m.owner == 1) ? 2 : (m.owner == 0) ? 1 : 0);
            chk("sel", int'(sel), (m.owner == 1) ? 1 : 0);
            chk("out_valid", int'(out_valid),
                (!reset && ((m.owner == 0 && in0_valid) || (m.owner == 1 && in1_valid))) ? 1 : 0);
            chk("in0_ready", int'(in0_ready), (!reset && m.owner == 0 && out_ready) ? 1 : 0);
            chk("in1_ready", int'(in1_ready), (!reset && m.owner == 1 && out_ready) ? 1 : 0);
            chk("out_data", int'(out_data), (m.owner == 1) ? int'(in1_data) : int'(in0_data));
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic at_neg();
        @(negedge clk);
    endtask

    task automatic do_reset();
        reset     = 1'b1;
        in0_valid = 1'b0;
        in1_valid = 1'b0;
        tick();
        tick();
        reset = 1'b0;
    endtask

    logic [WIDTH-1:0] got[$];
    int               idx;
    int               first_c;
    int               last_c;

    initial begin
        reset     = 1'b1;
        in0_valid = 1'b0;
        in1_valid = 1'b0;
        in0_data  = '0;
        in1_data  = '0;
        out_ready = 1'b0;

        // Reset with random inputs: everything idle.
        for (int c = 0; c < 2; c++) begin
            tick();
            in0_valid = 1'($urandom);
            in1_valid = 1'($urandom);
            in0_data  = WIDTH'($urandom);
            in1_data  = WIDTH'($urandom);
            out_ready = 1'($urandom);
            at_neg();
            chk("rst_grant", int'(grant), 0);
            chk("rst_sel", int'(sel), 0);
            chk("rst_out_valid", int'(out_valid), 0);
            chk("rst_ready", int'({in1_ready, in0_ready}), 0);
        end

        // Lone source 0: one idle cycle, then A0..A5 back to back.
        tick();
        reset     = 1'b0;
        in0_valid = 1'b1;
        in0_data  = 8'hA0;
        in1_valid = 1'b0;
        out_ready = 1'b1;
        idx       = 0;
        first_c   = -1;
        last_c    = -1;
        for (int c = 0; c < 9; c++) begin
            at_neg();
            if (c == 0) chk("t2_idle_grant", int'(grant), 0);
            if (c == 1) chk("t2_first_grant", int'(grant), 1);
            if (in0_ready && in0_valid) begin
                got.push_back(out_data);
                if (first_c < 0) first_c = c;
                last_c = c;
            end
            tick();
            if (got.size() > idx) begin
                idx      = got.size();
                in0_data = 8'(8'hA0 + idx);
                if (idx == 6) in0_valid = 1'b0;
            end
        end
        chk("t2_beats", got.size(), 6);
        for (int i = 0; i < got.size() && i < 6; i++) chk("t2_data", int'(got[i]), 8'hA0 + i);
        chk("t2_first_beat_cycle", first_c, 1);
        chk("t2_no_gap", last_c - first_c, 5);

        // Both valid, sink always ready: 4 beats each, alternating.
        do_reset();
        in0_valid = 1'b1;
        in1_valid = 1'b1;
        out_ready = 1'b1;
        for (int c = 0; c < 17; c++) begin
            at_neg();
            if (c == 0) begin
                chk("t3_idle_valid", int'(out_valid), 0);
            end else begin
                chk("t3_valid", int'(out_valid), 1);
                chk("t3_sel", int'(sel), ((c - 1) / 4) % 2);
            end
            tick();
            in0_data = WIDTH'($urandom);
            in1_data = WIDTH'($urandom);
        end

        // Stall after 2 beats of src0, then release; then src1 drops out.
        do_reset();
        in0_valid = 1'b1;
        in1_valid = 1'b1;
        out_ready = 1'b1;
        for (int c = 0; c < 16; c++) begin
            at_neg();
            if (c == 1 || c == 2 || c == 8 || c == 9) chk("t4_src0_beat", int'(in0_ready), 1);
            if (c >= 3 && c <= 7) begin
                chk("t4_stall_sel", int'(sel), 0);
                chk("t4_stall_in1_ready", int'(in1_ready), 0);
                chk("t4_stall_in0_ready", int'(in0_ready), 0);
            end
            if (c == 10) begin
                chk("t4_handoff_sel", int'(sel), 1);
                chk("t4_handoff_in1_ready", int'(in1_ready), 1);
            end
            if (c == 12) chk("t5_release_grant", int'(grant), 2);
            if (c == 13 || c == 14) chk("t5_idle_grant", int'(grant), 0);
            if (c == 15) chk("t5_tie_grant", int'(grant), 1);
            tick();
            if (c == 2)  out_ready = 1'b0;
            if (c == 7)  out_ready = 1'b1;
            if (c == 11) begin
                in0_valid = 1'b0;
                in1_valid = 1'b0;
            end
            if (c == 13) begin
                in0_valid = 1'b1;
                in1_valid = 1'b1;
            end
        end

        // Reset in the middle of a source-1 burst.
        do_reset();
        in1_valid = 1'b1;
        out_ready = 1'b1;
        for (int c = 0; c < 5; c++) begin
            at_neg();
            if (c == 1) chk("t6_g1_beat", int'(in1_ready), 1);
            if (c == 2) begin
                chk("t6_rst_in1_ready", int'(in1_ready), 0);
                chk("t6_rst_out_valid", int'(out_valid), 0);
            end
            if (c == 3) chk("t6_after_rst_grant", int'(grant), 0);
            if (c == 4) chk("t6_tie_grant", int'(grant), 1);
            tick();
            if (c == 1) reset = 1'b1;
            if (c == 2) begin
                reset     = 1'b0;
                in0_valid = 1'b1;
                in1_valid = 1'b1;
            end
        end

        // Randomized traffic with protocol-respecting sources.
        for (int c = 0; c < 4000; c++) begin
            at_neg();
            tick();
            reset     = ($urandom % 200) == 0;
            out_ready = ($urandom % 4) != 0;
            if (in0_valid && seen0) begin
                in0_valid = ($urandom % 4) != 0;
                in0_data  = WIDTH'($urandom);
            end else if (in0_valid) begin
                if ($urandom % 40 == 0) in0_valid = 1'b0;
            end else begin
                in0_valid = ($urandom % 3) == 0;
                in0_data  = WIDTH'($urandom);
            end
            if (in1_valid && seen1) begin
                in1_valid = ($urandom % 4) != 0;
                in1_data  = WIDTH'($urandom);
            end else if (in1_valid) begin
                if ($urandom % 40 == 0) in1_valid = 1'b0;
            end else begin
                in1_valid = ($urandom % 3) == 0;
                in1_data  = WIDTH'($urandom);
            end
        end

        at_neg();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
